// File: rtl/fe_pkg.sv
// Shared front-end definitions: RV32I mnemonics, opcodes, funct constants,
// the decoded-instruction record and immediate-extraction helpers.
package fe_pkg;

  typedef enum logic [5:0] {
    ILLEGAL = 6'd0,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, ECALL, EBREAK
  } RV32I_INSTRUCTION_t;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_S      = 7'b0100011,
    OP_B      = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } RV32I_OPCODE_t;

  // Operand layout used to pick register fields and immediate.
  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } rv32i_fmt_t;

  // Skid-buffer occupancy.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    RV32I_INSTRUCTION_t mnemonic;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [31:0]        imm;
    logic               illegal;
  } rv32i_decoded_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'd0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/rv32i_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface rv32i_decode_stage_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PC_WIDTH = 32
) ();
  import fe_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [PC_WIDTH-1:0] in_pc;

  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  RV32I_INSTRUCTION_t  out_mnemonic;
  logic [4:0]          out_rs1;
  logic [4:0]          out_rs2;
  logic [4:0]          out_rd;
  logic [XLEN-1:0]     out_imm;
  logic                out_illegal;

  // Decode stage side.
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_mnemonic,
           out_rs1, out_rs2, out_rd, out_imm, out_illegal
  );

  // Fetch/execute (environment) side.
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_mnemonic,
           out_rs1, out_rs2, out_rd, out_imm, out_illegal
  );
endinterface

// File: rtl/rv32i_decode_comb.sv
// Pure combinational RV32I decoder: instruction word -> rv32i_decoded_t.
module rv32i_decode_comb
  import fe_pkg::*;
(
  input  logic [31:0]    instr_i,
  output rv32i_decoded_t dec_o
);
  RV32I_OPCODE_t      opcode_s;
  logic [2:0]         funct3_s;
  logic [6:0]         funct7_s;
  RV32I_INSTRUCTION_t mn_s;
  rv32i_fmt_t         fmt_s;

  assign opcode_s = RV32I_OPCODE_t'(instr_i[6:0]);
  assign funct3_s = instr_i[14:12];
  assign funct7_s = instr_i[31:25];

  // Classify: mnemonic plus the operand format that selects fields.
  always_comb begin
    mn_s  = ILLEGAL;
    fmt_s = FMT_NONE;
    case (opcode_s)
      OP_LUI:   begin mn_s = LUI;   fmt_s = FMT_U; end
      OP_AUIPC: begin mn_s = AUIPC; fmt_s = FMT_U; end
      OP_JAL:   begin mn_s = JAL;   fmt_s = FMT_J; end
      OP_JALR: begin
        fmt_s = FMT_I;
        if (funct3_s == 3'b000) mn_s = JALR;
        else                    mn_s = ILLEGAL;
      end
      OP_B: begin
        fmt_s = FMT_B;
        case (funct3_s)
          3'b000:  mn_s = BEQ;
          3'b001:  mn_s = BNE;
          3'b100:  mn_s = BLT;
          3'b101:  mn_s = BGE;
          3'b110:  mn_s = BLTU;
          3'b111:  mn_s = BGEU;
          default: mn_s = ILLEGAL;
        endcase
      end
      OP_LOAD: begin
        fmt_s = FMT_I;
        case (funct3_s)
          3'b000:  mn_s = LB;
          3'b001:  mn_s = LH;
          3'b010:  mn_s = LW;
          3'b100:  mn_s = LBU;
          3'b101:  mn_s = LHU;
          default: mn_s = ILLEGAL;
        endcase
      end
      OP_S: begin
        fmt_s = FMT_S;
        case (funct3_s)
          3'b000:  mn_s = SB;
          3'b001:  mn_s = SH;
          3'b010:  mn_s = SW;
          default: mn_s = ILLEGAL;
        endcase
      end
      OP_I: begin
        fmt_s = FMT_I;
        case (funct3_s)
          F3_ADD:  mn_s = ADDI;
          3'b010:  mn_s = SLTI;
          3'b011:  mn_s = SLTIU;
          3'b100:  mn_s = XORI;
          3'b110:  mn_s = ORI;
          3'b111:  mn_s = ANDI;
          F3_SLL: begin
            fmt_s = FMT_SH;
            if (funct7_s == F7_ZERO) mn_s = SLLI;
            else                     mn_s = ILLEGAL;
          end
          F3_SR: begin
            fmt_s = FMT_SH;
            if (funct7_s == F7_ZERO)     mn_s = SRLI;
            else if (funct7_s == F7_ALT) mn_s = SRAI;
            else                         mn_s = ILLEGAL;
          end
          default: mn_s = ILLEGAL;
        endcase
      end
      OP_R: begin
        fmt_s = FMT_R;
        if (funct7_s == F7_ZERO) begin
          case (funct3_s)
            3'b000:  mn_s = ADD;
            3'b001:  mn_s = SLL;
            3'b010:  mn_s = SLT;
            3'b011:  mn_s = SLTU;
            3'b100:  mn_s = XOR;
            3'b101:  mn_s = SRL;
            3'b110:  mn_s = OR;
            3'b111:  mn_s = AND;
            default: mn_s = ILLEGAL;
          endcase
        end else if (funct7_s == F7_ALT) begin
          case (funct3_s)
            F3_ADD:  mn_s = SUB;
            F3_SR:   mn_s = SRA;
            default: mn_s = ILLEGAL;
          endcase
        end else begin
          mn_s = ILLEGAL;
        end
      end
      OP_FENCE: begin
        fmt_s = FMT_I;
        if (funct3_s == 3'b000) mn_s = FENCE;
        else                    mn_s = ILLEGAL;
      end
      OP_SYSTEM: begin
        fmt_s = FMT_I;
        if (instr_i == 32'h0000_0073)      mn_s = ECALL;
        else if (instr_i == 32'h0010_0073) mn_s = EBREAK;
        else                               mn_s = ILLEGAL;
      end
      default: mn_s = ILLEGAL;
    endcase
  end

  // Pull out the fields the format uses; anything illegal is forced to zero.
  always_comb begin
    dec_o          = '0;
    dec_o.mnemonic = mn_s;
    if (mn_s == ILLEGAL) begin
      dec_o.illegal = 1'b1;
    end else begin
      case (fmt_s)
        FMT_R:  begin dec_o.rs1 = instr_i[19:15]; dec_o.rs2 = instr_i[24:20]; dec_o.rd = instr_i[11:7]; end
        FMT_I:  begin dec_o.rs1 = instr_i[19:15]; dec_o.rd = instr_i[11:7]; dec_o.imm = imm_i(instr_i); end
        FMT_SH: begin dec_o.rs1 = instr_i[19:15]; dec_o.rd = instr_i[11:7]; dec_o.imm = {27'd0, instr_i[24:20]}; end
        FMT_S:  begin dec_o.rs1 = instr_i[19:15]; dec_o.rs2 = instr_i[24:20]; dec_o.imm = imm_s(instr_i); end
        FMT_B:  begin dec_o.rs1 = instr_i[19:15]; dec_o.rs2 = instr_i[24:20]; dec_o.imm = imm_b(instr_i); end
        FMT_U:  begin dec_o.rd = instr_i[11:7]; dec_o.imm = imm_u(instr_i); end
        FMT_J:  begin dec_o.rd = instr_i[11:7]; dec_o.imm = imm_j(instr_i); end
        default: dec_o.imm = 32'd0;
      endcase
    end
  end
endmodule

// File: rtl/rv32i_decode_stage.sv
// Registered RV32I decode stage: combinational decode feeding a 2-entry
// skid buffer so fetch sees a state-only in_ready under back-pressure.
module rv32i_decode_stage
  import fe_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  rv32i_decode_stage_if.slave bus
);
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    rv32i_decoded_t      dec;
  } entry_t;

  buf_state_t     state_q, state_d;
  entry_t         head_q, head_d;
  entry_t         skid_q, skid_d;
  entry_t         new_s;
  rv32i_decoded_t dec_s;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           in_xfer_s;
  logic           out_xfer_s;

  rv32i_decode_comb u_decode (
    .instr_i (bus.in_instr),
    .dec_o   (dec_s)
  );

  assign new_s.pc   = bus.in_pc;
  assign new_s.dec  = dec_s;
  assign in_xfer_s  = bus.in_valid && in_ready_q;
  assign out_xfer_s = out_valid_q && bus.out_ready;

  // Outputs come straight from registers: handshake flags and the head entry.
  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_pc       = head_q.pc;
  assign bus.out_mnemonic = head_q.dec.mnemonic;
  assign bus.out_rs1      = head_q.dec.rs1;
  assign bus.out_rs2      = head_q.dec.rs2;
  assign bus.out_rd       = head_q.dec.rd;
  assign bus.out_imm      = head_q.dec.imm[XLEN-1:0];
  assign bus.out_illegal  = head_q.dec.illegal;

  // Next buffer occupancy and contents; flush empties regardless of handshakes.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (in_xfer_s) begin
            head_d  = new_s;
            state_d = BUF_ONE;
          end else begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_ONE: begin
          case ({in_xfer_s, out_xfer_s})
            2'b10: begin skid_d = new_s; state_d = BUF_TWO; end
            2'b01: state_d = BUF_EMPTY;
            2'b11: head_d = new_s;
            default: state_d = BUF_ONE;
          endcase
        end
        BUF_TWO: begin
          if (out_xfer_s) begin
            head_d  = skid_q;
            state_d = BUF_ONE;
          end else begin
            state_d = BUF_TWO;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  // Buffer FSM registers; handshake flags are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= BUF_EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != BUF_TWO);
      out_valid_q <= (state_d != BUF_EMPTY);
    end
  end
endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Directed bench for rv32i_decode_stage with a queue scoreboard on the output side.
module tb_rv32i_decode_stage;
  import fe_pkg::*;

  typedef struct {
    logic [31:0]        instr;
    logic [31:0]        pc;
    RV32I_INSTRUCTION_t mn;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [31:0]        imm;
    logic               ill;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   total;
  int   bad;
  exp_t sb_q[$];
  exp_t cur_exp;
  exp_t tab[15];

  rv32i_decode_stage_if #(.XLEN(32), .PC_WIDTH(32)) bus ();

  rv32i_decode_stage #(.XLEN(32), .PC_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input RV32I_INSTRUCTION_t mn,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] imm, input logic ill);
    exp_t e;
    e.instr = instr; e.pc = 32'd0; e.mn = mn;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm; e.ill = ill;
    return e;
  endfunction

  // Scoreboard: compare on output transfer, record on input transfer, clear on flush/reset.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        check("out_has_expected", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_pc", bus.out_pc, e.pc);
          check("out_mnemonic", {26'd0, bus.out_mnemonic}, {26'd0, e.mn});
          check("out_rs1", {27'd0, bus.out_rs1}, {27'd0, e.rs1});
          check("out_rs2", {27'd0, bus.out_rs2}, {27'd0, e.rs2});
          check("out_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
          check("out_imm", bus.out_imm, e.imm);
          check("out_illegal", {31'd0, bus.out_illegal}, {31'd0, e.ill});
        end
      end
      if (flush) sb_q.delete();
      else if (bus.in_valid && bus.in_ready) sb_q.push_back(cur_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input exp_t e);
    bus.in_valid = 1'b1;
    bus.in_instr = e.instr;
    bus.in_pc    = e.pc;
    cur_exp      = e;
  endtask

  // Offer one instruction and hold it until the stage accepts it.
  task automatic send(input exp_t e);
    int k;
    k = 0;
    present(e);
    while (!bus.in_ready && k < 40) begin tick(); k++; end
    check("send_accept_in_time", {31'd0, k < 40}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && k < 40) begin tick(); k++; end
    check(tag, {31'd0, k < 40}, 32'd1);
  endtask

  function automatic exp_t at_pc(input exp_t e, input logic [31:0] pc);
    exp_t r;
    r = e;
    r.pc = pc;
    return r;
  endfunction

  initial begin
    exp_t a, b, c;
    int k;
    total = 0;
    bad   = 0;
    tab[0]  = mk(32'h00500093, ADDI,    5'd0, 5'd0, 5'd1, 32'h00000005, 1'b0);
    tab[1]  = mk(32'hFE000EE3, BEQ,     5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0);
    tab[2]  = mk(32'h123450B7, LUI,     5'd0, 5'd0, 5'd1, 32'h12345000, 1'b0);
    tab[3]  = mk(32'h008000EF, JAL,     5'd0, 5'd0, 5'd1, 32'h00000008, 1'b0);
    tab[4]  = mk(32'h00000000, ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1);
    tab[5]  = mk(32'h4230D093, ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1);
    tab[6]  = mk(32'h02309093, ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1);
    tab[7]  = mk(32'h4030D093, SRAI,    5'd1, 5'd0, 5'd1, 32'h00000003, 1'b0);
    tab[8]  = mk(32'h402081B3, SUB,     5'd1, 5'd2, 5'd3, 32'h00000000, 1'b0);
    tab[9]  = mk(32'h0020A423, SW,      5'd1, 5'd2, 5'd0, 32'h00000008, 1'b0);
    tab[10] = mk(32'hFFC0A283, LW,      5'd1, 5'd0, 5'd5, 32'hFFFFFFFC, 1'b0);
    tab[11] = mk(32'h02208133, ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1);
    tab[12] = mk(32'h0030D093, SRLI,    5'd1, 5'd0, 5'd1, 32'h00000003, 1'b0);
    tab[13] = mk(32'h00209463, BNE,     5'd1, 5'd2, 5'd0, 32'h00000008, 1'b0);
    tab[14] = mk(32'h004100E7, JALR,    5'd2, 5'd0, 5'd1, 32'h00000004, 1'b0);
    for (int i = 0; i < 15; i++) tab[i].pc = 32'h100 + 32'(i) * 32'd4;

    // Reset state.
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 32'd0; bus.out_ready = 1'b0;
    cur_exp = tab[0];
    repeat (3) tick();
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_out_imm", bus.out_imm, 32'd0);
    check("rst_out_mnemonic", {26'd0, bus.out_mnemonic}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Streaming decode, one per cycle, with first-result latency check.
    bus.out_ready = 1'b1;
    present(tab[0]);
    tick();
    check("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 1; i < 15; i++) begin
      present(tab[i]);
      check("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    drain("stream_drain");

    // Back-pressure: two accepted, third held, then released in order.
    bus.out_ready = 1'b0;
    a = at_pc(tab[2], 32'h200);
    b = at_pc(tab[8], 32'h204);
    c = at_pc(tab[4], 32'h208);
    send(a);
    send(b);
    check("bp_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
    present(c);
    tick();
    check("bp_in_ready_held", {31'd0, bus.in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("bp_head_pc", bus.out_pc, a.pc);
    tick();
    check("bp_hold_pc", bus.out_pc, a.pc);
    check("bp_hold_imm", bus.out_imm, a.imm);
    check("bp_hold_mnemonic", {26'd0, bus.out_mnemonic}, {26'd0, a.mn});
    bus.out_ready = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 10) begin tick(); k++; end
    check("bp_reopen_in_time", {31'd0, k < 10}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    drain("bp_drain");

    // Flush in TWO with a coincident incoming instruction.
    bus.out_ready = 1'b0;
    send(at_pc(tab[9], 32'h300));
    send(at_pc(tab[10], 32'h304));
    check("fl_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
    present(at_pc(tab[13], 32'h308));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("fl_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_stale_out", {31'd0, bus.out_valid}, 32'd0);
    end

    // Reset in TWO: everything discarded, outputs zeroed.
    bus.out_ready = 1'b0;
    send(at_pc(tab[3], 32'h400));
    send(at_pc(tab[7], 32'h404));
    present(at_pc(tab[1], 32'h408));
    rst_n = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check("rst2_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst2_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst2_out_pc", bus.out_pc, 32'd0);
    check("rst2_out_imm", bus.out_imm, 32'd0);
    check("rst2_out_rd", {27'd0, bus.out_rd}, 32'd0);
    check("rst2_out_rs1", {27'd0, bus.out_rs1}, 32'd0);
    check("rst2_out_illegal", {31'd0, bus.out_illegal}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst2_in_ready_rise", {31'd0, bus.in_ready}, 32'd1);
    check("rst2_out_valid_low", {31'd0, bus.out_valid}, 32'd0);

    // Stage still works after reset.
    bus.out_ready = 1'b1;
    send(at_pc(tab[14], 32'h500));
    drain("final_drain");
    check("sb_empty_at_end", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
